// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: accepts ALU commands, strobes operands into the ALU, waits for completion or timeout, returns a response
module alu_cmd_issuer #(
  parameter int DAT_W       = 144,
  parameter int STROBE_CYC  = 1,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [DAT_W:0]   cmd_a,
  input  logic [DAT_W-1:0] cmd_b,
  input  logic [DAT_W:0]   cmd_mod,
  input  logic             cmd_mod_ld,
  output logic             alu_o_sel,
  output logic             alu_t_sel,
  output logic             alu_mod_sel,
  output logic [3:0]       alu_typ_sel,
  output logic [DAT_W:0]   alu_o_dat,
  output logic [DAT_W-1:0] alu_t_dat,
  output logic [DAT_W:0]   alu_mod_dat,
  input  logic [DAT_W-1:0] alu_r_dat1,
  input  logic [DAT_W-1:0] alu_r_dat2,
  input  logic             compute_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_r1,
  output logic [DAT_W-1:0] rsp_r2,
  output logic             rsp_err,
  output logic             rsp_tmo,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int SW = $clog2(STROBE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t r_state, w_next;
  logic [SW-1:0] r_scnt;
  logic [TW-1:0] r_wcnt;
  logic r_mod_ld;
  logic w_acc, w_legal, w_sdone, w_tmo, w_done;
  assign w_acc   = cmd_valid && r_state == IDLE;
  assign w_legal = cmd_op inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
  assign w_sdone = r_scnt == SW'(STROBE_CYC - 1);
  assign w_tmo   = r_wcnt == TW'(TIMEOUT_CYC - 1);
  assign w_done  = r_state == WAIT && compute_done;
  assign cmd_ready   = r_state == IDLE;
  assign busy        = r_state != IDLE;
  assign rsp_valid   = r_state == RESP;
  assign alu_o_sel   = r_state == ISSUE;
  assign alu_t_sel   = r_state == ISSUE;
  assign alu_mod_sel = r_state == ISSUE && r_mod_ld;
  // state register
  always_ff @(posedge clk)
    r_state <= rst_b ? IDLE : w_next;
  // next-state: done beats the timeout on the same WAIT cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_acc ? (w_legal ? ISSUE : RESP) : IDLE;
      ISSUE:   w_next = w_sdone ? WAIT : ISSUE;
      WAIT:    w_next = (compute_done || w_tmo) ? RESP : WAIT;
      RESP:    w_next = rsp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  // command capture, strobe/wait counters and response registers
  always_ff @(posedge clk)
    if (rst_b) begin
      r_scnt      <= '0;
      r_wcnt      <= '0;
      r_mod_ld    <= 1'b0;
      alu_typ_sel <= '0;
      alu_o_dat   <= '0;
      alu_t_dat   <= '0;
      alu_mod_dat <= '0;
      rsp_r1      <= '0;
      rsp_r2      <= '0;
      rsp_err     <= 1'b0;
      rsp_tmo     <= 1'b0;
    end else begin
      r_scnt <= r_state == ISSUE ? r_scnt + 1'b1 : '0;
      r_wcnt <= r_state == WAIT ? r_wcnt + 1'b1 : '0;
      if (w_acc && w_legal) begin
        alu_o_dat   <= cmd_a;
        alu_t_dat   <= cmd_b;
        alu_typ_sel <= cmd_op;
        r_mod_ld    <= cmd_mod_ld;
        if (cmd_mod_ld) alu_mod_dat <= cmd_mod;
      end
      if (w_acc && !w_legal) begin
        rsp_r1  <= '0;
        rsp_r2  <= '0;
        rsp_err <= 1'b1;
        rsp_tmo <= 1'b0;
      end else if (w_done) begin
        rsp_r1  <= alu_r_dat1;
        rsp_r2  <= alu_r_dat2;
        rsp_err <= 1'b0;
        rsp_tmo <= 1'b0;
      end else if (r_state == WAIT && w_tmo) begin
        rsp_r1  <= '0;
        rsp_r2  <= '0;
        rsp_err <= 1'b0;
        rsp_tmo <= 1'b1;
      end
    end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: scoreboard bench for two issuer instances (1-cycle strobe/16-cycle timeout, 2-cycle strobe/default timeout)
module tb_alu_cmd_issuer;
  logic clk = 0;
  logic rst_b;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        cmd_valid[2], cmd_mod_ld[2], rsp_ready[2], spur[2];
  logic [3:0]  cmd_op[2];
  logic [16:0] cmd_a[2], cmd_mod[2];
  logic [15:0] cmd_b[2];
  logic        cmd_ready[2], o_sel[2], t_sel[2], m_sel[2], rsp_valid[2], rsp_err[2], rsp_tmo[2], busy[2];
  logic [3:0]  typ[2];
  logic [16:0] o_dat[2], m_dat[2];
  logic [15:0] t_dat[2], r1[2], r2[2];
  int          done_n[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic mdl_done;
    logic [15:0] mr1, mr2;
    int wc;
    bit armed;
    alu_cmd_issuer #(.DAT_W(16), .STROBE_CYC(g == 0 ? 1 : 2), .TIMEOUT_CYC(g == 0 ? 16 : 1023)) u_dut (
      .clk(clk), .rst_b(rst_b),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_op(cmd_op[g]),
      .cmd_a(cmd_a[g]), .cmd_b(cmd_b[g]), .cmd_mod(cmd_mod[g]), .cmd_mod_ld(cmd_mod_ld[g]),
      .alu_o_sel(o_sel[g]), .alu_t_sel(t_sel[g]), .alu_mod_sel(m_sel[g]), .alu_typ_sel(typ[g]),
      .alu_o_dat(o_dat[g]), .alu_t_dat(t_dat[g]), .alu_mod_dat(m_dat[g]),
      .alu_r_dat1(mr1), .alu_r_dat2(mr2), .compute_done(mdl_done | spur[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_r1(r1[g]), .rsp_r2(r2[g]),
      .rsp_err(rsp_err[g]), .rsp_tmo(rsp_tmo[g]), .busy(busy[g]));
    // ALU model: raises done in the done_n-th cycle after the strobes drop (0 = never)
    initial begin
      mdl_done = 0; mr1 = 0; mr2 = 0; armed = 0; wc = 0;
      forever begin
        @(posedge clk); #1;
        mdl_done = 0;
        if (!busy[g]) armed = 0;
        else if (o_sel[g]) begin armed = 1; wc = 0; end
        else if (armed) begin
          wc++;
          if (wc == done_n[g]) begin
            mdl_done = 1;
            armed = 0;
            mr1 = o_dat[g][15:0] + t_dat[g];
            mr2 = o_dat[g][16:1] ^ t_dat[g] ^ m_dat[g][15:0] ^ {12'h0, typ[g]};
          end
        end
      end
    end
  end

  typedef struct {
    logic [15:0] r1, r2;
    logic        err, tmo;
    int          lat, ostb, mstb;
    logic [3:0]  op;
    logic [16:0] a, m;
    logic [15:0] b;
  } exp_t;
  exp_t sb[$];
  logic [16:0] mod_last[2];
  int acc_cyc, n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int s_of(input int d); return d == 0 ? 1 : 2; endfunction
  function automatic int t_of(input int d); return d == 0 ? 16 : 1023; endfunction
  function automatic bit legal(input logic [3:0] op);
    return op inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
  endfunction

  task automatic send(input int d, input logic [3:0] op, input logic [16:0] a, input logic [15:0] b,
                      input logic [16:0] m, input logic ml, input int n);
    exp_t e;
    int k;
    bit lg = legal(op);
    if (lg && ml) mod_last[d] = m;
    e.op = op; e.a = a; e.b = b; e.m = mod_last[d];
    e.r1 = 0; e.r2 = 0; e.err = 0; e.tmo = 0;
    e.ostb = lg ? s_of(d) : 0;
    e.mstb = (lg && ml) ? s_of(d) : 0;
    if (!lg) begin e.err = 1; e.lat = 1; end
    else if (n == 0 || n > t_of(d)) begin e.tmo = 1; e.lat = 1 + s_of(d) + t_of(d); end
    else begin
      e.r1 = a[15:0] + b;
      e.r2 = a[16:1] ^ b ^ mod_last[d][15:0] ^ {12'h0, op};
      e.lat = 1 + s_of(d) + n;
    end
    sb.push_back(e);
    done_n[d] = n;
    cmd_valid[d] = 1; cmd_op[d] = op; cmd_a[d] = a; cmd_b[d] = b; cmd_mod[d] = m; cmd_mod_ld[d] = ml;
    for (k = 0; k < 100 && !cmd_ready[d]; k++) begin @(posedge clk); #1; end
    if (!cmd_ready[d]) check("cmd_ready_wait", 0, 1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid[d] = 0;
  endtask

  task automatic wait_rsp(input int d, input int hold);
    exp_t e;
    int no = 0, nm = 0, k;
    bit st = 1;
    for (k = 0; k < 3000 && !rsp_valid[d]; k++) begin
      no += int'(o_sel[d] && t_sel[d]);
      nm += int'(m_sel[d]);
      @(posedge clk); #1;
    end
    if (!rsp_valid[d]) begin
      check("rsp_wait", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    check("rsp_r1", r1[d], e.r1);
    check("rsp_r2", r2[d], e.r2);
    check("rsp_err", rsp_err[d], e.err);
    check("rsp_tmo", rsp_tmo[d], e.tmo);
    check("latency", cyc - acc_cyc, e.lat);
    check("ot_strobes", no, e.ostb);
    check("mod_strobes", nm, e.mstb);
    check("ready_in_resp", cmd_ready[d], 0);
    check("mod_dat", m_dat[d], e.m);
    if (!e.err) begin
      check("o_dat", o_dat[d], e.a);
      check("t_dat", t_dat[d], e.b);
      check("typ_sel", typ[d], e.op);
    end
    rsp_ready[d] = 0;
    repeat (hold) begin
      @(posedge clk); #1;
      st &= rsp_valid[d] && r1[d] == e.r1 && r2[d] == e.r2 && rsp_err[d] == e.err && rsp_tmo[d] == e.tmo;
    end
    check("hold_stable", st, 1);
    rsp_ready[d] = 1;
    @(posedge clk); #1;
    rsp_ready[d] = 0;
    check("post_handshake", {rsp_valid[d], cmd_ready[d], busy[d]}, 3'b010);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 0; cmd_mod_ld[d] = 0; rsp_ready[d] = 0; spur[d] = 0;
      cmd_op[d] = 0; cmd_a[d] = 0; cmd_b[d] = 0; cmd_mod[d] = 0; done_n[d] = 0; mod_last[d] = 0;
    end
    rst_b = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 0;
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", cmd_ready[d], 1);
      check("rst_sel", {o_sel[d], t_sel[d], m_sel[d]}, 0);
      check("rst_flags", {rsp_valid[d], rsp_err[d], rsp_tmo[d], busy[d]}, 0);
      check("rst_dat", {o_dat[d], t_dat[d], m_dat[d], typ[d]}, 0);
      check("rst_rsp", {r1[d], r2[d]}, 0);
    end
    send(0, 4'b0001, 17'h0fff1, 16'h0f0f, 17'h0, 0, 1);
    wait_rsp(0, 0);
    send(1, 4'b0011, 17'h1a5a5, 16'h3c3c, 17'h1beef, 1, 100);
    wait_rsp(1, 5);
    send(1, 4'b0010, 17'h01234, 16'h5678, 17'h0dead, 0, 3);
    wait_rsp(1, 1);
    send(0, 4'b0100, 17'h11111, 16'h2222, 17'h0, 0, 1);
    wait_rsp(0, 0);
    spur[0] = 1;
    @(posedge clk); #1;
    spur[0] = 0;
    repeat (3) begin
      check("spurious_done", {rsp_valid[0], busy[0]}, 0);
      @(posedge clk); #1;
    end
    send(0, 4'b1000, 17'h00042, 16'h0007, 17'h0, 0, 0);
    wait_rsp(0, 2);
    send(0, 4'b1001, 17'h10203, 16'h0405, 17'h0, 0, 16);
    wait_rsp(0, 0);
    send(0, 4'b1111, 17'h1ffff, 16'hffff, 17'h1ffff, 1, 1);
    wait_rsp(0, 0);
    send(1, 4'b0101, 17'h0abcd, 16'h0011, 17'h10001, 1, 0);
    repeat (10) @(posedge clk);
    #1;
    check("div_in_wait", busy[1], 1);
    rst_b = 1;
    @(posedge clk); #1;
    rst_b = 0;
    void'(sb.pop_back());
    mod_last[0] = 0; mod_last[1] = 0;
    check("rstw_busy", busy[1], 0);
    check("rstw_sel", {o_sel[1], t_sel[1], m_sel[1]}, 0);
    check("rstw_rsp", {rsp_valid[1], rsp_err[1], rsp_tmo[1]}, 0);
    check("rstw_mod", m_dat[1], 0);
    send(1, 4'b0001, 17'h00100, 16'h0200, 17'h0, 0, 4);
    wait_rsp(1, 0);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter DAT_W, default 144, polynomial/operand width in bits.
REQ-002 SHALL have parameter STROBE_CYC, default 1, number of cycles the ALU select strobes stay high (range 1-4).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1023, maximum cycles waited for compute_done.
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have ports: rst_b  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports: cmd_valid in 1, cmd_ready out 1: command handshake.
REQ-007 SHALL have ports: cmd_op in 4: ALU operation code; cmd_a in DAT_W+1: operand O; cmd_b in DAT_W: operand T; cmd_mod in DAT_W+1: modulus; cmd_mod_ld in 1: load modulus with this command.
REQ-008 SHALL have ports: alu_o_sel, alu_t_sel, alu_mod_sel out 1 each; alu_typ_sel out 4; alu_o_dat out DAT_W+1; alu_t_dat out DAT_W; alu_mod_dat out DAT_W+1.
REQ-009 SHALL have ports: alu_r_dat1, alu_r_dat2 in DAT_W; compute_done in 1: ALU result interface.
REQ-010 SHALL have ports: rsp_valid out 1, rsp_ready in 1; rsp_r1, rsp_r2 out DAT_W; rsp_err out 1 (illegal op); rsp_tmo out 1 (timeout); busy out 1 (state != IDLE).

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-012 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on cmd_valid&cmd_ready.
REQ-013 SHALL treat opcodes 0001,0010,0011,0101,0110,0111,1000,1001 as legal; others SHALL go IDLE->RESP with rsp_err=1, rsp_r1/rsp_r2=0, no strobe asserted.
REQ-014 On legal accept SHALL register cmd_a, cmd_b, cmd_op (and cmd_mod when cmd_mod_ld=1) onto alu_o_dat, alu_t_dat, alu_typ_sel (alu_mod_dat) and enter ISSUE next cycle.
REQ-015 In ISSUE SHALL hold alu_o_sel=alu_t_sel=1 for exactly STROBE_CYC cycles; alu_mod_sel=1 for the same cycles only if cmd_mod_ld was 1; then go to WAIT.
REQ-016 SHALL keep alu_o_dat/alu_t_dat/alu_typ_sel/alu_mod_dat stable from ISSUE entry until return to IDLE; alu_mod_dat retains last loaded value across commands.
REQ-017 SHALL ignore compute_done in IDLE, ISSUE and RESP; sampled only in WAIT.
REQ-018 In WAIT, compute_done=1 SHALL capture alu_r_dat1/alu_r_dat2 into rsp_r1/rsp_r2, clear rsp_err/rsp_tmo, go RESP next cycle.
REQ-019 WAIT cycle counter SHALL start at 0 on WAIT entry; if it reaches TIMEOUT_CYC without compute_done, SHALL go RESP with rsp_tmo=1, results 0.
REQ-020 compute_done on the same cycle the counter reaches TIMEOUT_CYC SHALL win (normal completion, rsp_tmo=0).
REQ-021 In RESP rsp_valid=1 and rsp_* held stable until rsp_ready=1; then IDLE next cycle.
REQ-022 Issue-to-response latency SHALL be: 1 (accept) + STROBE_CYC + N (WAIT cycles up to and incl. done) cycles; illegal op: rsp_valid the cycle after accept.
REQ-023 SHALL not accept a new command in the cycle rsp handshake completes (cmd_ready rises one cycle later).

Reset
REQ-024 rst_b=1 at a clock edge SHALL force IDLE from any state, abandoning in-flight commands without a response.
REQ-025 Reset values: cmd_ready=1 after reset release, all *_sel=0, alu_typ_sel=0, alu_*_dat=0, rsp_valid=0, rsp_r1/rsp_r2=0, rsp_err=0, rsp_tmo=0, busy=0, counter=0.

Verification
REQ-026 Add: op=0001, a=16'hfff1, b=16'h0f0f, mod_ld=0; ALU model done after 1 cycle -> one o/t strobe cycle, alu_mod_sel=0, rsp_valid with model results, rsp_err=0.
REQ-027 Mul with modulus: op=0011, mod_ld=1, STROBE_CYC=2; done after 100 cycles -> mod_sel high 2 cycles with o/t, rsp arrives 1+2+100 cycles after accept, rsp_ready held low 5 cycles -> outputs stable.
REQ-028 Illegal op 4'b0100 -> no strobe, rsp_valid next cycle with rsp_err=1; spurious compute_done pulse in IDLE -> no response.
REQ-029 Timeout: TIMEOUT_CYC=16, model never asserts done -> rsp_tmo=1 after 16 WAIT cycles; second run with done at cycle 16 -> rsp_tmo=0, results captured.
REQ-030 Reset mid-WAIT during division (op=0101) -> busy=0, all sel=0, rsp_valid=0 next cycle, following add command completes normally.
